// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared CRC constants, FSM encoding and byte-wise CRC-32 helper
package eth_rx_pkg;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
        return c;
    endfunction
endpackage

// File: rtl/fcs_delay_line.sv
// fcs_delay_line: enable-gated byte shift register; the tail register drives data_out
module fcs_delay_line #(
    parameter int P_NUM_DELAY = 4,
    parameter int P_WIDTH     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [P_WIDTH-1:0] data_in,
    output logic [P_WIDTH-1:0] data_out
);
    logic [P_NUM_DELAY-1:0][P_WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n) sr <= '0;
        else if (en) sr <= {sr[P_NUM_DELAY-2:0], data_in};
    end

    assign data_out = sr[P_NUM_DELAY-1];
endmodule

// File: rtl/rx_fcs_strip.sv
// rx_fcs_strip: withholds the trailing FCS from the RX byte stream and reports CRC/length status per frame
module rx_fcs_strip
    import eth_rx_pkg::*;
#(
    parameter int P_FCS_BYTES = 4,
    parameter int P_MIN_FRAME = 64,
    parameter int P_MAX_FRAME = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        frame_done,
    output logic        frame_good,
    output logic        err_crc,
    output logic        err_len,
    output logic        err_abort,
    output logic [10:0] byte_count
);
    localparam logic [10:0] FCS_N   = 11'(P_FCS_BYTES);
    localparam logic [10:0] MIN_LEN = 11'(P_MIN_FRAME);
    localparam logic [10:0] MAX_LEN = 11'(P_MAX_FRAME);

    logic [1:0]  state;
    logic [10:0] cnt, cnt_nx;
    logic [31:0] crc, crc_nx;
    logic [7:0]  dl_out;
    logic        accept, abort, emit, eof, crc_bad, len_bad;

    assign accept  = in_valid && (in_sof || state != ST_IDLE);
    assign abort   = in_valid && in_sof && state != ST_IDLE;
    assign emit    = accept && !in_sof && state == ST_STREAM;
    assign eof     = accept && in_eof;
    assign cnt_nx  = in_sof ? 11'd1 : (cnt == 11'h7ff ? cnt : cnt + 11'd1);
    assign crc_nx  = crc32_byte(in_sof ? CRC_INIT : crc, in_data);
    assign crc_bad = crc_nx != CRC_RESIDUE;
    assign len_bad = cnt_nx < MIN_LEN || cnt_nx > MAX_LEN || state != ST_STREAM || in_sof;

    fcs_delay_line #(.P_NUM_DELAY(P_FCS_BYTES), .P_WIDTH(8)) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (accept),
        .data_in  (in_data),
        .data_out (dl_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            crc        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            err_crc    <= 1'b0;
            err_len    <= 1'b0;
            err_abort  <= 1'b0;
            byte_count <= '0;
        end else begin
            out_valid  <= emit;
            out_last   <= emit && in_eof;
            frame_done <= eof || abort;
            if (emit) out_data <= dl_out;
            if (accept) begin
                cnt   <= cnt_nx;
                crc   <= crc_nx;
                state <= in_eof ? ST_IDLE :
                         in_sof ? ST_FILL :
                         (state == ST_FILL && cnt_nx == FCS_N) ? ST_STREAM : state;
            end
            // an sof arriving mid-frame reports the cut frame; a coincident eof flags the 1-byte frame as short
            if (abort) begin
                frame_good <= 1'b0;
                err_crc    <= 1'b0;
                err_len    <= in_eof;
                err_abort  <= 1'b1;
                byte_count <= cnt;
            end else if (eof) begin
                frame_good <= !crc_bad && !len_bad;
                err_crc    <= crc_bad;
                err_len    <= len_bad;
                err_abort  <= 1'b0;
                byte_count <= cnt_nx;
            end
        end
    end
endmodule
